// File: rtl/mux_sync_pkg.sv
// Shared types for the mux bus synchroniser.
// FSM encoding and handshake-mode selectors.
package mux_sync_pkg;

  typedef enum logic [1:0] {
    IDLE,
    VALID,
    ACK_WAIT
  } mux_sync_state_t;

  localparam int HS_FOUR_PHASE = 0;
  localparam int HS_TWO_PHASE  = 1;

endpackage

// File: rtl/sync_bit_srst.sv
// Single-bit N-flop synchroniser.
// Synchronous active-high reset clears the whole chain.
module sync_bit_srst #(
  parameter int NUM_OF_SYNC_FLOPS = 2
) (
  input  logic dest_clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  if (NUM_OF_SYNC_FLOPS < 2) begin : g_bad_depth
    $error("sync_bit_srst: NUM_OF_SYNC_FLOPS must be >= 2");
  end

  logic [NUM_OF_SYNC_FLOPS-1:0] sf;

  always_ff @(posedge dest_clk) begin
    if (rst) begin
      sf <= '0;
    end else begin
      sf <= {sf[NUM_OF_SYNC_FLOPS-2:0], d};
    end
  end

  assign q = sf[NUM_OF_SYNC_FLOPS-1];

endmodule

// File: rtl/mux_bus_sync.sv
// Mux bus synchroniser: only req crosses, data_in is sampled on capture.
// Source sees ack, consumer sees valid/ready.
module mux_bus_sync
  import mux_sync_pkg::*;
#(
  parameter int               WIDTH             = 8,
  parameter int               NUM_OF_SYNC_FLOPS = 2,
  parameter logic [WIDTH-1:0] RESET_VAL         = '0,
  parameter int               HS_MODE           = 0
) (
  input  logic             dest_clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             req,
  output logic             ack,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             dest_ready,
  output logic             err_protocol
);

  if (WIDTH < 1) begin : g_bad_width
    $error("mux_bus_sync: WIDTH must be >= 1");
  end
  if (HS_MODE != HS_FOUR_PHASE && HS_MODE != HS_TWO_PHASE) begin : g_bad_mode
    $error("mux_bus_sync: HS_MODE must be 0 or 1");
  end

  localparam bit TWO_PH = (HS_MODE == HS_TWO_PHASE);

  logic            req_s;
  logic            req_s_d;
  logic            ev;
  mux_sync_state_t state;

  sync_bit_srst #(
    .NUM_OF_SYNC_FLOPS(NUM_OF_SYNC_FLOPS)
  ) u_req_sync (
    .dest_clk(dest_clk),
    .rst     (rst),
    .d       (req),
    .q       (req_s)
  );

  assign ev = TWO_PH ? (req_s ^ req_s_d) : req_s;

  always_ff @(posedge dest_clk) begin
    if (rst) begin
      state        <= IDLE;
      req_s_d      <= 1'b0;
      ack          <= 1'b0;
      data_out     <= RESET_VAL;
      data_valid   <= 1'b0;
      err_protocol <= 1'b0;
    end else begin
      req_s_d <= req_s;
      case (state)
        IDLE: begin
          if (ev) begin
            data_out   <= data_in;
            data_valid <= 1'b1;
            state      <= VALID;
          end
        end
        VALID: begin
          // early withdrawal (4-phase) or overrun (2-phase); word is kept
          if ((!TWO_PH && !req_s) || (TWO_PH && ev)) begin
            err_protocol <= 1'b1;
          end
          if (dest_ready) begin
            data_valid <= 1'b0;
            if (TWO_PH) begin
              ack   <= ~ack;
              state <= IDLE;
            end else begin
              ack   <= 1'b1;
              state <= ACK_WAIT;
            end
          end
        end
        ACK_WAIT: begin
          if (!req_s) begin
            ack   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_bus_sync.sv
// Directed bench for mux_bus_sync.
// One 4-phase instance and one 2-phase instance share clock, reset and bus.
module tb_mux_bus_sync;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       req0 = 1'b0;
  logic       rdy0 = 1'b0;
  logic       req1 = 1'b0;
  logic       rdy1 = 1'b0;

  logic       ack0, dv0, err0;
  logic [7:0] dout0;
  logic       ack1, dv1, err1;
  logic [7:0] dout1;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mux_bus_sync #(
    .WIDTH(8), .NUM_OF_SYNC_FLOPS(2),
    .RESET_VAL(8'hFF), .HS_MODE(0)
  ) u_dut0 (
    .dest_clk    (clk),
    .rst         (rst),
    .data_in     (din),
    .req         (req0),
    .ack         (ack0),
    .data_out    (dout0),
    .data_valid  (dv0),
    .dest_ready  (rdy0),
    .err_protocol(err0)
  );

  mux_bus_sync #(
    .WIDTH(8), .NUM_OF_SYNC_FLOPS(2),
    .RESET_VAL(8'h00), .HS_MODE(1)
  ) u_dut1 (
    .dest_clk    (clk),
    .rst         (rst),
    .data_in     (din),
    .req         (req1),
    .ack         (ack1),
    .data_out    (dout1),
    .data_valid  (dv1),
    .dest_ready  (rdy1),
    .err_protocol(err1)
  );

  task automatic check(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // reset
    tick(2);
    check("rst_dout0", dout0, 8'hFF);
    check("rst_dv0", {7'b0, dv0}, 8'h00);
    check("rst_ack0", {7'b0, ack0}, 8'h00);
    check("rst_err0", {7'b0, err0}, 8'h00);
    check("rst_dout1", dout1, 8'h00);
    check("rst_ack1", {7'b0, ack1}, 8'h00);
    rst = 1'b0;

    // 1: 4-phase basic transfer
    din = 8'hA5; rdy0 = 1'b1; req0 = 1'b1;
    tick(2);
    check("t1_dv_early", {7'b0, dv0}, 8'h00);
    tick();
    check("t1_dv", {7'b0, dv0}, 8'h01);
    check("t1_dout", dout0, 8'hA5);
    check("t1_ack_pre", {7'b0, ack0}, 8'h00);
    tick();
    check("t1_dv_off", {7'b0, dv0}, 8'h00);
    check("t1_ack", {7'b0, ack0}, 8'h01);
    req0 = 1'b0;
    tick(2);
    check("t1_ack_hold", {7'b0, ack0}, 8'h01);
    tick();
    check("t1_ack_drop", {7'b0, ack0}, 8'h00);
    check("t1_err", {7'b0, err0}, 8'h00);

    // 2: backpressure
    din = 8'h3C; rdy0 = 1'b0; req0 = 1'b1;
    tick(3);
    for (int i = 0; i < 10; i++) begin
      check("t2_dv", {7'b0, dv0}, 8'h01);
      check("t2_dout", dout0, 8'h3C);
      check("t2_ack", {7'b0, ack0}, 8'h00);
      tick();
    end
    rdy0 = 1'b1;
    tick();
    check("t2_dv_off", {7'b0, dv0}, 8'h00);
    check("t2_ack", {7'b0, ack0}, 8'h01);
    req0 = 1'b0;
    tick(3);
    check("t2_ack_drop", {7'b0, ack0}, 8'h00);
    check("t2_err", {7'b0, err0}, 8'h00);

    // 3: 2-phase three transfers
    rdy1 = 1'b1;
    for (int w = 1; w <= 3; w++) begin
      din = 8'(w);
      req1 = ~req1;
      tick(3);
      check("t3_dv", {7'b0, dv1}, 8'h01);
      check("t3_dout", dout1, 8'(w));
      tick();
      check("t3_dv_off", {7'b0, dv1}, 8'h00);
      check("t3_ack", {7'b0, ack1}, {7'b0, w[0]});
    end
    check("t3_final_ack", {7'b0, ack1}, 8'h01);
    check("t3_err", {7'b0, err1}, 8'h00);

    // 4: 2-phase overrun
    rdy1 = 1'b0;
    din = 8'h11; req1 = ~req1;
    tick(3);
    check("t4_dv", {7'b0, dv1}, 8'h01);
    check("t4_dout", dout1, 8'h11);
    check("t4_err_pre", {7'b0, err1}, 8'h00);
    din = 8'h22; req1 = ~req1;
    tick(3);
    check("t4_err", {7'b0, err1}, 8'h01);
    check("t4_dout_kept", dout1, 8'h11);
    rdy1 = 1'b1;
    tick();
    check("t4_dv_off", {7'b0, dv1}, 8'h00);
    check("t4_ack", {7'b0, ack1}, 8'h00);
    tick(3);
    check("t4_no_recap", {7'b0, dv1}, 8'h00);
    check("t4_err_sticky", {7'b0, err1}, 8'h01);
    check("t4_dout_hold", dout1, 8'h11);

    // 5: 4-phase early withdrawal
    rdy0 = 1'b0; din = 8'h77; req0 = 1'b1;
    tick(3);
    check("t5_dv", {7'b0, dv0}, 8'h01);
    req0 = 1'b0;
    tick(2);
    check("t5_err_pre", {7'b0, err0}, 8'h00);
    tick();
    check("t5_err", {7'b0, err0}, 8'h01);
    check("t5_dv_held", {7'b0, dv0}, 8'h01);
    check("t5_dout", dout0, 8'h77);
    rdy0 = 1'b1;
    tick();
    check("t5_ack", {7'b0, ack0}, 8'h01);
    tick();
    check("t5_ack_drop", {7'b0, ack0}, 8'h00);
    check("t5_err_sticky", {7'b0, err0}, 8'h01);

    // 6: reset mid-transfer
    rdy0 = 1'b0; din = 8'h5A; req0 = 1'b1;
    tick(3);
    check("t6_dout_pre", dout0, 8'h5A);
    rst = 1'b1;
    tick();
    check("t6_dout", dout0, 8'hFF);
    check("t6_dv", {7'b0, dv0}, 8'h00);
    check("t6_ack", {7'b0, ack0}, 8'h00);
    check("t6_err", {7'b0, err0}, 8'h00);
    check("t6_err1", {7'b0, err1}, 8'h00);
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    tick(3);
    check("t6_idle", {7'b0, dv0}, 8'h00);
    din = 8'hC3; rdy0 = 1'b1; req0 = 1'b1;
    tick(3);
    check("t6_new_dv", {7'b0, dv0}, 8'h01);
    check("t6_new_dout", dout0, 8'hC3);
    tick();
    check("t6_new_ack", {7'b0, ack0}, 8'h01);
    req0 = 1'b0;
    tick(3);
    check("t6_new_ack_drop", {7'b0, ack0}, 8'h00);
    check("t6_new_err", {7'b0, err0}, 8'h00);
    check("t6_dv1", {7'b0, dv1}, 8'h00);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
